// File: rtl/melody_seq_pkg.sv
// Shared definitions for the note sequencer: note codes, status layout,
// FSM state encoding and CPU register addresses.
package melody_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Codes understood by beep.mode: 1..13 chromatic C..C, 14 low B, 0 silent.
    localparam logic [7:0] NOTE_REST = 8'd0;
    localparam logic [7:0] NOTE_C    = 8'd1;
    localparam logic [7:0] NOTE_CS   = 8'd2;
    localparam logic [7:0] NOTE_D    = 8'd3;
    localparam logic [7:0] NOTE_DS   = 8'd4;
    localparam logic [7:0] NOTE_E    = 8'd5;
    localparam logic [7:0] NOTE_F    = 8'd6;
    localparam logic [7:0] NOTE_FS   = 8'd7;
    localparam logic [7:0] NOTE_G    = 8'd8;
    localparam logic [7:0] NOTE_GS   = 8'd9;
    localparam logic [7:0] NOTE_A    = 8'd10;
    localparam logic [7:0] NOTE_AS   = 8'd11;
    localparam logic [7:0] NOTE_B    = 8'd12;
    localparam logic [7:0] NOTE_C_HI = 8'd13;
    localparam logic [7:0] NOTE_B_LO = 8'd14;

    localparam int STAT_FULL_BIT  = 8;
    localparam int STAT_EMPTY_BIT = 9;
    localparam int STAT_BUSY_BIT  = 10;
    localparam int STAT_OVF_BIT   = 11;

    localparam logic [31:0] ADDR_NOTE_WR = 32'hff18;
    localparam logic [31:0] ADDR_CLEAR   = 32'hff1c;
    localparam logic [31:0] ADDR_STATUS  = 32'hff18;

    function automatic logic [31:0] pack_status(
        input logic [4:0] cnt,
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf
    );
        logic [31:0] s;
        s                 = '0;
        s[4:0]            = cnt;
        s[STAT_FULL_BIT]  = full;
        s[STAT_EMPTY_BIT] = empty;
        s[STAT_BUSY_BIT]  = busy;
        s[STAT_OVF_BIT]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/melody_seq_if.sv
// CPU-side bus of the note sequencer: push/clear strobes in, beep mode,
// status word and drain pulse out.
interface melody_seq_if;
    import melody_seq_pkg::*;

    logic        wr_note;
    logic [15:0] wr_data;
    logic        clear;
    logic [7:0]  mode;
    logic [31:0] status;
    logic        done;

    modport master (
        output wr_note, wr_data, clear,
        input  mode, status, done
    );

    modport slave (
        input  wr_note, wr_data, clear,
        output mode, status, done
    );

endinterface

// File: rtl/melody_seq_note_fifo.sv
// DEPTH x WIDTH register-array FIFO with combinational head read, flush,
// and push+pop allowed on the same edge even when full.
module note_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    import melody_seq_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/melody_seq.sv
// Note sequencer feeding beep.mode: plays queued {duration, note} entries in
// order, each for duration x TICK_CYCLES clocks followed by an optional silent gap.
module melody_seq
    import melody_seq_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int TICK_CYCLES = 625000,
    parameter int GAP_TICKS   = 1
) (
    input  logic         clk_62p5mhz,
    input  logic         reset,
    melody_seq_if.slave  bus
);

    localparam int              CNT_W    = $clog2(DEPTH) + 1;
    localparam int              PRE_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
    localparam logic [7:0]      GAP_T8   = 8'(GAP_TICKS);

    state_e           state_q, state_d;
    logic [7:0]       mode_q, mode_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [7:0]       tick_q, tick_d;
    logic [7:0]       dur_q, dur_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [15:0]      head;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             wrap;
    logic [7:0]       tick_inc;

    // clear takes priority: a simultaneous write is discarded outright.
    assign push     = bus.wr_note && !bus.clear;
    assign pop      = (state_q == ST_IDLE) && !empty && !bus.clear;
    assign ovf_set  = push && full && !pop;
    assign wrap     = (presc_q == PRE_LAST);
    assign tick_inc = tick_q + 8'd1;

    note_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk_62p5mhz),
        .rst     (reset),
        .push    (push),
        .pop     (pop),
        .flush   (bus.clear),
        .wr_data (bus.wr_data),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        dur_d   = dur_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q | ovf_set;
        if (bus.clear) begin
            state_d = ST_IDLE;
            mode_d  = '0;
            presc_d = '0;
            tick_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    mode_d = '0;
                    if (!empty) begin
                        presc_d = '0;
                        tick_d  = '0;
                        dur_d   = head[15:8];
                        // Zero-length entries are consumed without sound or gap.
                        if (head[15:8] != 8'd0) begin
                            state_d = ST_PLAY;
                            mode_d  = head[7:0];
                        end
                    end
                end
                ST_PLAY: begin
                    if (wrap) begin
                        presc_d = '0;
                        tick_d  = tick_inc;
                        if (tick_inc == dur_q) begin
                            tick_d = '0;
                            mode_d = '0;
                            if (GAP_TICKS > 0) begin
                                state_d = ST_GAP;
                            end else begin
                                state_d = ST_IDLE;
                                done_d  = empty;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PRE_W'(1);
                    end
                end
                ST_GAP: begin
                    if (wrap) begin
                        presc_d = '0;
                        tick_d  = tick_inc;
                        if (tick_inc == GAP_T8) begin
                            tick_d  = '0;
                            state_d = ST_IDLE;
                            done_d  = empty;
                        end
                    end else begin
                        presc_d = presc_q + PRE_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    mode_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_62p5mhz or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            presc_q <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.mode   = mode_q;
    assign bus.done   = done_q;
    assign bus.status = pack_status(5'(count), full, empty, state_q != ST_IDLE, ovf_q);

endmodule

// File: tb/tb_melody_seq.sv
// Directed bench for melody_seq: two instances (gap of one tick, and legato)
// with TICK_CYCLES=4, DEPTH=4; expected values are hand-computed.
module tb_melody_seq;

    logic clk = 1'b0;
    logic reset;
    int   n_chk;
    int   n_fail;

    melody_seq_if i0 ();
    melody_seq_if i1 ();

    melody_seq #(.DEPTH(4), .TICK_CYCLES(4), .GAP_TICKS(1)) dut0 (
        .clk_62p5mhz (clk),
        .reset       (reset),
        .bus         (i0)
    );

    melody_seq #(.DEPTH(4), .TICK_CYCLES(4), .GAP_TICKS(0)) dut1 (
        .clk_62p5mhz (clk),
        .reset       (reset),
        .bus         (i1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit en0, input bit en1, input logic wn,
                         input logic [15:0] wd, input logic clr);
        i0.wr_note = en0 & wn;
        i0.wr_data = en0 ? wd : 16'h0;
        i0.clear   = en0 & clr;
        i1.wr_note = en1 & wn;
        i1.wr_data = en1 ? wd : 16'h0;
        i1.clear   = en1 & clr;
    endtask

    task automatic idle_in();
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    // Hand pattern for notes 1,5,8 of one tick: 4 cycles on, then (spacing-4) cycles silent.
    function automatic logic [7:0] b2b_exp(input int t, input int spacing);
        logic [7:0] nt [3];
        int idx;
        nt[0] = 8'd1;
        nt[1] = 8'd5;
        nt[2] = 8'd8;
        idx   = t / spacing;
        if (idx < 3 && (t % spacing) < 4) return nt[idx];
        return 8'd0;
    endfunction

    initial begin
        logic [7:0] seq [$];
        logic [7:0] prev;
        int         d0, d1, bad;
        bit         reached;

        n_chk  = 0;
        n_fail = 0;
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_status0", i0.status, 32'h200);
        check_eq("rst_status1", i1.status, 32'h200);
        check_eq("rst_mode0", {24'h0, i0.mode}, 32'h0);
        check_eq("rst_done0", {31'h0, i0.done}, 32'h0);
        reset = 1'b0;
        step();

        // Single note: dur 2, note 10
        drive(1'b1, 1'b0, 1'b1, 16'h020A, 1'b0);
        step();
        idle_in();
        check_eq("t1_mode_k", {24'h0, i0.mode}, 32'h0);
        check_eq("t1_status_k", i0.status, 32'h001);
        step();
        check_eq("t1_mode_k1", {24'h0, i0.mode}, 32'd10);
        check_eq("t1_status_k1", i0.status, 32'h600);
        for (int i = 2; i <= 8; i++) begin
            step();
            check_eq($sformatf("t1_hold[%0d]", i), {24'h0, i0.mode}, 32'd10);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("t1_gap[%0d]", i), {23'h0, i0.done, i0.mode}, 32'h0);
            check_eq($sformatf("t1_gap_busy[%0d]", i), {31'h0, i0.status[10]}, 32'h1);
        end
        step();
        check_eq("t1_done", {31'h0, i0.done}, 32'h1);
        check_eq("t1_status_end", i0.status, 32'h200);
        step();
        check_eq("t1_done_one_cycle", {31'h0, i0.done}, 32'h0);

        // Back-to-back notes 1,5,8 on both instances
        d0 = 0;
        d1 = 0;
        drive(1'b1, 1'b1, 1'b1, 16'h0101, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b1, 16'h0105, 1'b0);
        step();
        check_eq("t2_g1[0]", {24'h0, i0.mode}, {24'h0, b2b_exp(0, 9)});
        check_eq("t2_g0[0]", {24'h0, i1.mode}, {24'h0, b2b_exp(0, 5)});
        drive(1'b1, 1'b1, 1'b1, 16'h0108, 1'b0);
        step();
        idle_in();
        for (int t = 1; t < 40; t++) begin
            if (t > 1) step();
            check_eq($sformatf("t2_g1[%0d]", t), {24'h0, i0.mode}, {24'h0, b2b_exp(t, 9)});
            check_eq($sformatf("t2_g0[%0d]", t), {24'h0, i1.mode}, {24'h0, b2b_exp(t, 5)});
            d0 += int'(i0.done);
            d1 += int'(i1.done);
        end
        check_eq("t2_done_g1", d0, 1);
        check_eq("t2_done_g0", d1, 1);
        check_eq("t2_status_g1", i0.status, 32'h200);
        check_eq("t2_status_g0", i1.status, 32'h200);

        // Overflow while a long note holds playback
        drive(1'b1, 1'b0, 1'b1, 16'h0202, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 16'h0103, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 16'h0104, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 16'h0105, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 16'h0106, 1'b0);
        step();
        check_eq("t3_full_status", i0.status, 32'h504);
        drive(1'b1, 1'b0, 1'b1, 16'h0109, 1'b0);
        step();
        idle_in();
        check_eq("t3_ovf_status", i0.status, 32'hD04);
        check_eq("t3_mode_long", {24'h0, i0.mode}, 32'd2);
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            step();
            if (i0.status[10] == 1'b0) reached = 1'b1;
        end
        check_eq("t3_idle_reached", {31'h0, reached}, 32'h1);
        check_eq("t3_idle_status", i0.status, 32'h904);
        drive(1'b1, 1'b0, 1'b1, 16'h010B, 1'b0);
        step();
        idle_in();
        check_eq("t3_pushpop_status", i0.status, 32'hD04);
        check_eq("t3_pushpop_mode", {24'h0, i0.mode}, 32'd3);
        seq.delete();
        seq.push_back(i0.mode);
        prev = i0.mode;
        d0   = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (i0.mode != 8'd0 && prev == 8'd0) seq.push_back(i0.mode);
            prev = i0.mode;
            d0 += int'(i0.done);
        end
        check_eq("t3_played_count", seq.size(), 5);
        if (seq.size() == 5) begin
            check_eq("t3_seq0", {24'h0, seq[0]}, 32'd3);
            check_eq("t3_seq1", {24'h0, seq[1]}, 32'd4);
            check_eq("t3_seq2", {24'h0, seq[2]}, 32'd5);
            check_eq("t3_seq3", {24'h0, seq[3]}, 32'd6);
            check_eq("t3_seq4", {24'h0, seq[4]}, 32'd11);
        end
        check_eq("t3_done_count", d0, 1);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        step();
        idle_in();
        check_eq("t3_clear_ovf", i0.status, 32'h200);

        // Zero-duration entry is skipped without a gap
        drive(1'b1, 1'b0, 1'b1, 16'h0003, 1'b0);
        step();
        check_eq("t4_mode_k", {24'h0, i0.mode}, 32'h0);
        check_eq("t4_status_k", i0.status, 32'h001);
        drive(1'b1, 1'b0, 1'b1, 16'h0107, 1'b0);
        step();
        idle_in();
        check_eq("t4_mode_skip", {24'h0, i0.mode}, 32'h0);
        check_eq("t4_status_skip", i0.status, 32'h001);
        step();
        check_eq("t4_mode_7", {24'h0, i0.mode}, 32'd7);
        check_eq("t4_status_7", i0.status, 32'h600);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("t4_hold[%0d]", i), {24'h0, i0.mode}, 32'd7);
        end
        step();
        check_eq("t4_gap", {24'h0, i0.mode}, 32'h0);
        repeat (8) step();
        check_eq("t4_idle", i0.status, 32'h200);

        // Clear mid-note with two entries queued
        drive(1'b1, 1'b0, 1'b1, 16'h0501, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 16'h0102, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 16'h0103, 1'b0);
        step();
        idle_in();
        step();
        step();
        check_eq("t5_before_clear_mode", {24'h0, i0.mode}, 32'd1);
        check_eq("t5_before_clear_status", i0.status, 32'h402);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        step();
        idle_in();
        check_eq("t5_clear_mode", {24'h0, i0.mode}, 32'h0);
        check_eq("t5_clear_status", i0.status, 32'h200);
        check_eq("t5_clear_done", {31'h0, i0.done}, 32'h0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i0.mode != 8'd0 || i0.done) bad++;
        end
        check_eq("t5_quiet_after_clear", bad, 0);
        drive(1'b1, 1'b0, 1'b1, 16'h0104, 1'b1);
        step();
        idle_in();
        check_eq("t5_clear_wins", i0.status, 32'h200);
        step();
        check_eq("t5_clear_wins_mode", {24'h0, i0.mode}, 32'h0);

        // Asynchronous reset in the middle of a note
        drive(1'b1, 1'b0, 1'b1, 16'h0204, 1'b0);
        step();
        idle_in();
        step();
        step();
        check_eq("t6_playing", {24'h0, i0.mode}, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_async_mode", {24'h0, i0.mode}, 32'h0);
        check_eq("t6_async_status", i0.status, 32'h200);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i0.mode != 8'd0 || i0.status != 32'h200) bad++;
        end
        check_eq("t6_idle_after_release", bad, 0);
        drive(1'b1, 1'b0, 1'b1, 16'h0105, 1'b0);
        step();
        idle_in();
        step();
        check_eq("t6_replay", {24'h0, i0.mode}, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
